// File: rtl/bus_mem_if.sv
// Single-master system bus between an initiator and a memory-side responder.
// The master drives the request fields; the slave returns ack and read data.
interface bus_mem_if;
  logic        bus_en;
  logic        wr_rd;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wr_data;
  logic        ack;
  logic [31:0] rd_data;

  modport master (
    output bus_en,
    output wr_rd,
    output addr,
    output size,
    output wr_data,
    input  ack,
    input  rd_data
  );

  modport slave (
    input  bus_en,
    input  wr_rd,
    input  addr,
    input  size,
    input  wr_data,
    output ack,
    output rd_data
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Word-organised RAM responder: latches one request, waits LATENCY cycles,
// commits writes / registers read data at the edge entering ACK, pulses ack.
module bus_mem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  bus_mem_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic [31:0] mem_q [DEPTH];

  logic          enter_ack;
  logic          commit;
  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [4:0]    shamt;
  logic [31:0]   wdata_sh;

  // The unsigned bit of the size encoding has no effect on a full-word return.
  logic unused_size;
  assign unused_size = bus.size[2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    wr_d      = wr_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.bus_en) begin
          addr_d  = bus.addr;
          wdata_d = bus.wr_data;
          size_d  = bus.size[1:0];
          wr_d    = bus.wr_rd;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d   = StAck;
          enter_ack = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decode from the next-state copy so LATENCY=1 uses the request being accepted.
  always_comb begin
    offset = addr_d - BASE_ADDR;
    hit    = offset < SPAN;
    idx    = offset[AW+1:2];
    be     = 4'b1111;
    shamt  = 5'd0;
    unique case (size_d)
      2'b00: begin
        be    = 4'b0001 << addr_d[1:0];
        shamt = {addr_d[1:0], 3'b000};
      end
      2'b01: begin
        be    = addr_d[1] ? 4'b1100 : 4'b0011;
        shamt = {addr_d[1], 4'b0000};
      end
      default: begin
        be    = 4'b1111;
        shamt = 5'd0;
      end
    endcase
    wdata_sh  = wdata_d << shamt;
    commit    = enter_ack && wr_d && hit;
    rd_data_d = '0;
    if (enter_ack && !wr_d && hit) begin
      rd_data_d = mem_q[idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM survives reset; a reset edge still blocks the commit it coincides with.
  always_ff @(posedge i_clk) begin
    if (i_rst && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign bus.ack     = (state_q == StAck);
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 4) checked against a
// word-array model, fixed vectors, corner-case sequences and random traffic.
module tb_bus_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, en1 = 1'b0;
  logic        t_wr = 1'b0;
  logic [31:0] t_addr = '0;
  logic [2:0]  t_size = '0;
  logic [31:0] t_wdata = '0;

  bus_mem_if bif0 ();
  bus_mem_if bif1 ();

  assign bif0.bus_en  = en0;
  assign bif0.wr_rd   = t_wr;
  assign bif0.addr    = t_addr;
  assign bif0.size    = t_size;
  assign bif0.wr_data = t_wdata;
  assign bif1.bus_en  = en1;
  assign bif1.wr_rd   = t_wr;
  assign bif1.addr    = t_addr;
  assign bif1.size    = t_size;
  assign bif1.wr_data = t_wdata;

  bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif0)
  );

  bus_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) u_dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [2][DEPTH];
  logic        in_txn [2];
  logic        prev_ack [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [2:0] sz, input logic [31:0] d);
    int          lane;
    logic [31:0] mask;
    case (sz[1:0])
      2'b00:   begin lane = int'(a % 4);           mask = 32'h0000_00FF; end
      2'b01:   begin lane = int'((a % 4) / 2) * 2; mask = 32'h0000_FFFF; end
      default: begin lane = 0;                     mask = 32'hFFFF_FFFF; end
    endcase
    mask = mask << (8 * lane);
    return (old & ~mask) | ((d << (8 * lane)) & mask);
  endfunction

  task automatic model_write(input int sel, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d);
    if (model_hit(a)) model[sel][model_idx(a)] = merge(model[sel][model_idx(a)], a, sz, d);
  endtask

  function automatic logic [31:0] model_read(input int sel, input logic [31:0] a);
    return model_hit(a) ? model[sel][model_idx(a)] : 32'h0;
  endfunction

  // Bus monitor: ack is a single pulse, only inside a transaction, data 0 otherwise.
  always begin
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      logic        a;
      logic [31:0] r;
      a = (s == 0) ? bif0.ack : bif1.ack;
      r = (s == 0) ? bif0.rd_data : bif1.rd_data;
      check($sformatf("ack_double[%0d]", s), {31'b0, a && prev_ack[s]}, 32'h0);
      check($sformatf("ack_unsolicited[%0d]", s), {31'b0, a && !in_txn[s]}, 32'h0);
      if (!a) check($sformatf("rd_idle_zero[%0d]", s), r, 32'h0);
      prev_ack[s] = a;
    end
  end

  task automatic txn(input int sel, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d, output logic [31:0] rd);
    int   j;
    logic got;
    int   lat;
    lat = (sel == 0) ? 2 : 4;
    @(negedge clk);
    t_wr = wr; t_addr = a; t_size = sz; t_wdata = d;
    in_txn[sel] = 1'b1;
    if (sel == 0) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk);
    j = 0;
    got = 1'b0;
    while (!got && j < 40) begin
      @(negedge clk);
      if (((sel == 0) ? bif0.ack : bif1.ack) == 1'b1) got = 1'b1;
      else j++;
    end
    en0 = 1'b0; en1 = 1'b0;
    rd = (sel == 0) ? bif0.rd_data : bif1.rd_data;
    check($sformatf("ack_seen[%0d]", sel), {31'b0, got}, 32'h1);
    if (got) check($sformatf("ack_latency[%0d]", sel), 32'(j), 32'(lat - 1));
    @(posedge clk);
    in_txn[sel] = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [2:0]  size;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
    logic        wr;
    int          sel;
    int          acks;

    in_txn[0] = 1'b0; in_txn[1] = 1'b0;
    prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;

    vecs[0]  = '{1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 3'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h20, 3'd2, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 32'h22, 3'd0, 32'h0000_00AA, 32'h0};
    vecs[4]  = '{1'b1, 32'h20, 3'd1, 32'h0000_BBCC, 32'h0};
    vecs[5]  = '{1'b0, 32'h20, 3'd2, 32'h0,         32'h11AA_BBCC};
    vecs[6]  = '{1'b1, 32'h00, 3'd2, 32'hCAFE_F00D, 32'h0};
    vecs[7]  = '{1'b0, SPAN,   3'd2, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, SPAN,   3'd2, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, 32'h00, 3'd2, 32'h0,         32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'h23, 3'd1, 32'h0000_9999, 32'h0};
    vecs[11] = '{1'b1, 32'h21, 3'd0, 32'hFFFF_FF77, 32'h0};
    vecs[12] = '{1'b0, 32'h20, 3'd6, 32'h0,         32'h9999_77CC};
    vecs[13] = '{1'b1, 32'h24, 3'd3, 32'hA5A5_A5A5, 32'h0};
    vecs[14] = '{1'b0, 32'h24, 3'd2, 32'h0,         32'hA5A5_A5A5};
    vecs[15] = '{1'b0, 32'hFFFF_FFFC, 3'd2, 32'h0,  32'h0};

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("reset_ack0", {31'b0, bif0.ack}, 32'h0);
    check("reset_rd0", bif0.rd_data, 32'h0);
    check("reset_ack1", {31'b0, bif1.ack}, 32'h0);
    check("reset_rd1", bif1.rd_data, 32'h0);
    repeat (20) @(negedge clk);

    // Preload every word of both RAMs with known data.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < int'(DEPTH); w++) begin
        d = $urandom;
        txn(s, 1'b1, BASE + 32'(w * 4), 3'd2, d, rd);
        model[s][w] = d;
      end
    end

    foreach (vecs[i]) begin
      txn(0, vecs[i].wr, BASE + vecs[i].off, vecs[i].size, vecs[i].data, rd);
      if (vecs[i].wr) model_write(0, BASE + vecs[i].off, vecs[i].size, vecs[i].data);
      else check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    // LATENCY=4: inputs change and bus_en drops during WAIT.
    @(negedge clk);
    t_wr = 1'b1; t_addr = BASE + 32'h40; t_size = 3'd2; t_wdata = 32'h0BAD_CAFE;
    in_txn[1] = 1'b1;
    en1 = 1'b1;
    @(posedge clk);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        t_addr = BASE + 32'h44; t_wdata = 32'hFFFF_FFFF; en1 = 1'b0;
      end
      if (bif1.ack) acks++;
    end
    check("wait_single_ack", 32'(acks), 32'd1);
    @(posedge clk);
    in_txn[1] = 1'b0;
    model[1][16] = 32'h0BAD_CAFE;
    txn(1, 1'b0, BASE + 32'h40, 3'd2, 32'h0, rd);
    check("wait_latched_write", rd, 32'h0BAD_CAFE);
    txn(1, 1'b0, BASE + 32'h44, 3'd2, 32'h0, rd);
    check("wait_other_word", rd, model[1][17]);

    // Reset while a write sits in WAIT: no ack and no commit.
    txn(0, 1'b1, BASE + 32'h30, 3'd2, 32'h0, rd);
    model[0][12] = 32'h0;
    @(negedge clk);
    t_wr = 1'b1; t_addr = BASE + 32'h30; t_size = 3'd2; t_wdata = 32'h55;
    en0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bif0.ack) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    txn(0, 1'b0, BASE + 32'h30, 3'd2, 32'h0, rd);
    check("rst_no_commit", rd, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(1, 0));
      wr  = $urandom_range(1, 0) == 1;
      sz  = 3'($urandom);
      d   = $urandom;
      case ($urandom_range(7, 0))
        0:       a = BASE + SPAN + 32'($urandom_range(63, 0));
        1:       a = BASE - 32'($urandom_range(64, 1));
        default: a = BASE + 32'($urandom_range(int'(SPAN) - 1, 0));
      endcase
      txn(sel, wr, a, sz, d, rd);
      if (wr) model_write(sel, a, sz, d);
      else check($sformatf("rand%0d_rd[%0d]@%h", n, sel, a), rd, model_read(sel, a));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the single-master system bus driven by the hart/arbiter tops: samples a request (enable, read/write, address, size, write data), services it from an internal word-organised RAM after a configurable number of wait states, and returns a one-cycle acknowledge with read data. It sits at the far end of the arbiter output and is the default memory target in simulation and FPGA builds.

## Interface

- `DEPTH`, 4096: RAM size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH*4`.
- `LATENCY`, 2: cycles from request acceptance to `o_ack`; legal range 1..15.
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-low.
- `i_bus_en`  in  1  request valid; held high by the initiator until it samples `o_ack`.
- `i_wr_rd`  in  1  1 = write, 0 = read.
- `i_addr`  in  32  byte address.
- `i_size`  in  3  access size, funct3 encoding: [1:0] 00 byte, 01 half, 10 word; bit 2 (unsigned) ignored by this block.
- `i_wr_data`  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- `o_ack`  out  1  one-cycle completion pulse.
- `o_rd_data`  out  32  full aligned RAM word for reads; valid only while `o_ack`=1, else 0.

## Operation

- FSM states: IDLE, WAIT, ACK.
- IDLE: on edge with `i_bus_en`=1, latch addr, size, wr_rd, wr_data; load wait counter with `LATENCY-1`; go to ACK if `LATENCY`=1, else WAIT.
- WAIT: counter decrements each edge; at 0 → ACK. `i_*` inputs ignored (latched copy used); `i_bus_en` dropping early does not abort.
- ACK: `o_ack`=1 for this cycle only; next state IDLE unconditionally. A new request is accepted no earlier than the IDLE cycle following ACK.
- Address decode: hit when `i_addr - BASE_ADDR < DEPTH*4`; word index = offset[log2(DEPTH)+1:2].
- Byte lanes (from latched addr[1:0] and size): byte → lane addr[1:0], data shifted left 8*addr[1:0]; half → lanes {addr[1],0}/+1, shift 16*addr[1], addr[0] ignored; word → all lanes, addr[1:0] ignored. Size 11 treated as word.
- Write: masked lanes updated at the edge entering ACK; other lanes unchanged.
- Read: `o_rd_data` = RAM word at latched index, registered at the edge entering ACK.
- Miss (out of range): still acknowledged after `LATENCY`; read returns 32'h0; write discarded.
- RAM contents are not cleared by reset; simulation preload via `$readmemh` hook is outside this spec's timing.

## Timing

- Reset (`i_rst`=0 at an edge): state IDLE, counter 0, `o_ack`=0, `o_rd_data`=0, latched request cleared. Reset during WAIT/ACK aborts the transaction; a write not yet committed (state WAIT) is never performed; a write committed at the ACK-entry edge remains.
- Latency: request sampled at edge N → `o_ack` high during cycle after edge N+`LATENCY`-1, i.e. LATENCY=1: ack in the cycle immediately after acceptance.
- Throughput: one transaction per `LATENCY`+1 cycles with back-to-back requests.
- Read-after-write to the same word in consecutive transactions returns the new data.
- `o_ack` never high two consecutive cycles; never high without a preceding accepted request.

## Test plan

- Reset then idle: `i_rst`=0 two cycles, `i_bus_en`=0 → `o_ack`=0, `o_rd_data`=0 throughout 20 cycles.
- Word write/read, LATENCY=2: write 32'hDEADBEEF @ BASE+0x10, then read same → each ack exactly 2 cycles after acceptance; read returns 32'hDEADBEEF.
- Byte/half lanes: word 32'h11223344 @ 0x20; write byte 32'hAA @ 0x22, half 32'hBBCC @ 0x20 → read returns 32'h11AABBCC.
- Out-of-range: read @ BASE+DEPTH*4 → ack after LATENCY, data 0; write there then read word 0 → word 0 unchanged.
- Input change during WAIT (LATENCY=4): change `i_addr`/`i_wr_data` and drop `i_bus_en` mid-wait → original latched write lands, single ack.
- Reset mid-operation: write 32'h55 @ 0x30 (previously 0), assert `i_rst` in WAIT → no ack; later read @ 0x30 returns 0.
